// File: rtl/sram_wb_port0_ctrl.sv
// Wishbone classic slave mapping a BASE_ADDR window onto single-port SRAM port 0.
// Define SRAM_WB_READ_CACHE_EN to add a one-entry read cache that short-circuits repeat reads.
module sram_wb_port0_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [31:0]           sram_din0,
    input  logic [31:0]           sram_dout0
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

    state_t                state_q;
    logic                  ack_q;
    logic                  csb_q;
    logic                  web_q;
    logic                  we_q;
    logic                  abort_q;
    logic [31:0]           dat_q;
    logic [31:0]           din_q;
    logic [3:0]            wmask_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  req_sel;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  capture_ok;
    logic                  rd_hit;
    logic [31:0]           hit_data;
    logic                  unused_adr_lsb;

    assign word_addr      = wbs_adr_i[ADDR_WIDTH+1:2];
    assign req_sel        = wbs_cyc_i & wbs_stb_i &
                            (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    // A read is only delivered if the cycle survived both ACCESS and CAPTURE.
    assign capture_ok     = (state_q == CAPTURE) & ~abort_q & wbs_cyc_i;
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

`ifdef SRAM_WB_READ_CACHE_EN
    logic                  cache_vld_q;
    logic [ADDR_WIDTH-1:0] cache_adr_q;
    logic [31:0]           cache_dat_q;

    assign rd_hit   = ~wbs_we_i & cache_vld_q & (cache_adr_q == word_addr);
    assign hit_data = cache_dat_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cache_vld_q <= 1'b0;
            cache_adr_q <= '0;
            cache_dat_q <= '0;
        end else if (capture_ok) begin
            cache_vld_q <= 1'b1;
            cache_adr_q <= addr_q;
            cache_dat_q <= sram_dout0;
        end else if ((state_q == IDLE) && req_sel && wbs_we_i && (cache_adr_q == word_addr)) begin
            cache_vld_q <= 1'b0;
        end
    end
`else
    assign rd_hit   = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            csb_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (req_sel) begin
                        addr_q  <= word_addr;
                        din_q   <= wbs_dat_i;
                        we_q    <= wbs_we_i;
                        web_q   <= ~wbs_we_i;
                        wmask_q <= wbs_we_i ? wbs_sel_i : 4'hF;
                        abort_q <= 1'b0;
                        if (rd_hit) begin
                            dat_q   <= hit_data;
                            ack_q   <= 1'b1;
                            state_q <= ACK;
                        end else begin
                            csb_q   <= 1'b0;
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        ack_q   <= wbs_cyc_i;
                        state_q <= wbs_cyc_i ? ACK : IDLE;
                    end else begin
                        abort_q <= ~wbs_cyc_i;
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    dat_q   <= sram_dout0;
                    ack_q   <= capture_ok;
                    state_q <= capture_ok ? ACK : IDLE;
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

endmodule

// File: tb/tb_sram_wb_port0_ctrl.sv
// Randomized bench for sram_wb_port0_ctrl against a word-level memory/latency reference model.
// Honors SRAM_WB_READ_CACHE_EN the same way the design does.
module tb_sram_wb_port0_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int unsigned AW   = 8;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we_i = 1'b0;
    logic [3:0]    sel_i = '0;
    logic [31:0]   adr_i = '0, dat_i = '0;
    logic          ack;
    logic [31:0]   dat_o;
    logic          csb0, web0;
    logic [3:0]    wmask0;
    logic [AW-1:0] addr0;
    logic [31:0]   din0;
    logic [31:0]   sram_dout = '0;

    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem  [256];
    bit          cv = 1'b0;
    logic [7:0]  ca = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sram_wb_port0_ctrl #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetb(resetb),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
        .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .sram_csb0(csb0), .sram_web0(web0), .sram_wmask0(wmask0), .sram_addr0(addr0),
        .sram_din0(din0), .sram_dout0(sram_dout)
    );

    // Behavioural SRAM: one-cycle registered read, byte-masked write.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) sram_mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end else begin
                sram_dout <= sram_mem[addr0];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; keep leaves stb/cyc high for a back-to-back follow-up.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit keep);
        logic [7:0] w;
        bit         inwin, hit, done;
        int         lat, csb_n, exp_lat, exp_csb, limit;
        w     = adr[9:2];
        inwin = ((adr ^ BASE) >> 10) == 32'd0;
        hit   = 1'b0;
`ifdef SRAM_WB_READ_CACHE_EN
        hit   = !we && cv && (ca == w);
`endif
        exp_lat = !inwin ? -1 : (we ? 2 : (hit ? 1 : 3));
        exp_csb = (inwin && !hit) ? 1 : 0;
        limit   = inwin ? 12 : 10;
        cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        lat = -1; csb_n = 0; done = 1'b0;
        for (int k = 0; k < limit && !done; k++) begin
            @(negedge clk);
            if (!csb0) begin
                csb_n++;
                check_eq("addr0", 32'(addr0), 32'(w));
                check_eq("web0", 32'(web0), 32'(!we));
                check_eq("wmask0", 32'(wmask0), we ? 32'(sel) : 32'hF);
                if (we) check_eq("din0", din0, dat);
            end
            if (ack) begin
                lat  = k;
                done = 1'b1;
                if (!we) check_eq("rdata", dat_o, ref_mem[w]);
            end
            @(posedge clk); #1;
        end
        check_eq(inwin ? "ack_latency" : "no_ack_outside", 32'(lat), 32'(exp_lat));
        check_eq("csb_pulses", 32'(csb_n), 32'(exp_csb));
        if (inwin && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[w][b*8 +: 8] = dat[b*8 +: 8];
            if (cv && ca == w) cv = 1'b0;
        end else if (inwin) begin
            cv = 1'b1;
            ca = w;
        end
        if (!keep) begin
            cyc = 1'b0; stb = 1'b0;
        end
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_dat", dat_o, 32'd0);
        check_eq("rst_csb", 32'(csb0), 32'd1);
        check_eq("rst_web", 32'(web0), 32'd1);
        check_eq("rst_wmask", 32'(wmask0), 32'd0);
        check_eq("rst_addr", 32'(addr0), 32'd0);
        check_eq("rst_din", din0, 32'd0);
        resetb = 1'b1;
        @(posedge clk); #1;

        wb_xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        wb_xfer(1'b1, 32'h3000_0010, 32'h1122_3344, 4'b0101, 1'b0);
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'h0, 1'b0);
        check_eq("partial_merge", dat_o, 32'hDE22_BE44);
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'h0, 1'b0);
        wb_xfer(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'hF, 1'b0);
        wb_xfer(1'b0, 32'h3000_0012, 32'h0, 4'h0, 1'b0);
        check_eq("reread_new", dat_o, 32'hCAFE_F00D);
        check_eq("dat_hold", dat_o, 32'hCAFE_F00D);
        wb_xfer(1'b1, 32'h3000_0400, 32'h5555_AAAA, 4'hF, 1'b0);

        // Abort: cyc dropped while the read is in ACCESS.
        wb_xfer(1'b1, 32'h3000_0020, 32'h0BAD_F00D, 4'hF, 1'b0);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0020;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) acks++;
            @(posedge clk); #1;
        end
        check_eq("abort_no_ack", 32'(acks), 32'd0);
        wb_xfer(1'b1, 32'h3000_0024, 32'h1234_5678, 4'hF, 1'b0);

        // Reset pulse while the read sits in CAPTURE.
        wb_xfer(1'b1, 32'h3000_0030, 32'hA5A5_5A5A, 4'hF, 1'b0);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0030;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetb = 1'b0; cyc = 1'b0; stb = 1'b0;
        #1;
        check_eq("midrst_csb", 32'(csb0), 32'd1);
        check_eq("midrst_ack", 32'(ack), 32'd0);
        check_eq("midrst_dat", dat_o, 32'd0);
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack) acks++;
            @(posedge clk);
        end
        #1;
        check_eq("midrst_no_ack", 32'(acks), 32'd0);
        resetb = 1'b1;
        cv = 1'b0;
        @(posedge clk); #1;
        wb_xfer(1'b0, 32'h3000_0030, 32'h0, 4'h0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] adr;
            bit          keep;
            if ($urandom_range(0, 9) == 0)
                adr = 32'h3000_0400 + (32'($urandom_range(0, 255)) << 2);
            else if ($urandom_range(0, 4) == 0)
                adr = BASE + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
            else
                adr = BASE + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            keep = (t != 149) && ($urandom_range(0, 3) == 0);
            wb_xfer(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)), keep);
            if (!keep)
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_wb_port0_ctrl.md
SRAM_WB_PORT0_CTRL -- requirements
Module: sram_wb_port0_ctrl

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, default 32'h3000_0000, 1 KiB-aligned window base; ADDR_WIDTH, default 8, SRAM word-address width.
REQ-002 `clk` input 1: the single clock; the SRAM port 0 clock is this same net.
REQ-003 `resetb` input 1: reset, asynchronous, active-low.
REQ-004 `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` inputs 1 each: Wishbone classic cycle, strobe and write-enable.
REQ-005 `wbs_sel_i` input 4: byte lane selects. `wbs_adr_i` input 32: byte address. `wbs_dat_i` input 32: write data.
REQ-006 `wbs_ack_o` output 1: transfer acknowledge. `wbs_dat_o` output 32: read data.
REQ-007 `sram_csb0` output 1: active-low chip select to the SRAM. `sram_web0` output 1: active-low write enable to the SRAM.
REQ-008 `sram_wmask0` output 4, `sram_addr0` output ADDR_WIDTH, `sram_din0` output 32: SRAM port-0 request.
REQ-009 `sram_dout0` input 32: SRAM port-0 read data.

Function
REQ-010 A request SHALL be selected when `wbs_cyc_i & wbs_stb_i` is high and `wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`; unselected requests SHALL be ignored, with no ack.
REQ-011 The word address SHALL be `wbs_adr_i[ADDR_WIDTH+1:2]`; `wbs_adr_i[1:0]` SHALL be ignored.
REQ-012 The FSM states SHALL be IDLE, ACCESS, CAPTURE and ACK, all driven from registered outputs.
REQ-013 IDLE: on a selected request, the block SHALL register the address, data, sel and we, then go to ACCESS.
REQ-014 ACCESS: the block SHALL drive `sram_csb0`=0 for exactly one cycle. `sram_web0` SHALL be `~we`. `sram_wmask0` SHALL be sel for writes and 4'hF for reads.
REQ-015 ACCESS transitions: a write SHALL go to ACK; a read SHALL go to CAPTURE.
REQ-016 CAPTURE: the block SHALL hold `sram_csb0`=1 and latch `sram_dout0` into `wbs_dat_o` at the closing edge, then go to ACK.
REQ-017 ACK: the block SHALL drive `wbs_ack_o`=1 for exactly one cycle, then go to IDLE.
REQ-018 Latency from the selected-request edge to the ack cycle SHALL be 2 cycles for a write and 3 cycles for a read.
REQ-019 Back-to-back requests SHALL be allowed: if stb is still high in IDLE after an ack, it SHALL be treated as a new request.
REQ-020 `sram_csb0` SHALL be 1 in every state except ACCESS.
REQ-021 `wbs_dat_o` SHALL hold its last captured value until the next capture.
REQ-022 Abort: if `wbs_cyc_i` falls in ACCESS or CAPTURE, the SRAM access SHALL complete, but ACK SHALL be skipped and the FSM SHALL return to IDLE.
REQ-023 `sram_din0` SHALL equal the registered write data during ACCESS; its value in other states is don't-care.

Reset
REQ-024 On `resetb`=0 the block SHALL immediately force: state=IDLE, `wbs_ack_o`=0, `wbs_dat_o`=0, `sram_csb0`=1, `sram_web0`=1, `sram_wmask0`=0, `sram_addr0`=0, `sram_din0`=0.
REQ-025 Reset asserted mid-transaction SHALL abort the transaction with no ack; after release, the first selected request SHALL be serviced normally.

Configuration
REQ-026 Macro `SRAM_WB_READ_CACHE_EN` defined: the block SHALL keep a one-entry cache of {valid, word address, data} from the last completed read.
REQ-027 With the cache enabled, a read hitting a valid entry SHALL go IDLE->ACK (ack 1 cycle after request) with no SRAM access (`sram_csb0` stays 1).
REQ-028 With the cache enabled, any write to the cached address SHALL invalidate the entry; reset SHALL also clear valid.
REQ-029 Macro `SRAM_WB_READ_CACHE_EN` undefined: every read SHALL take the REQ-018 path and no cache storage SHALL exist.

Verification
REQ-030 Reset release, then write adr 0x3000_0010, sel 4'hF, data 0xDEADBEEF -> one ACCESS cycle with addr0=4, web0=0, wmask0=F; ack 2 cycles after the request.
REQ-031 Partial write of 0x11223344 with sel 4'b0101 to the same address, then a read -> `wbs_dat_o`=0xDE22BE44, ack 3 cycles after the read request.
REQ-032 Request to adr 0x3000_0400 (outside the window) -> no `sram_csb0` pulse and no ack for 10 cycles.
REQ-033 Read request with `resetb` pulsed low during CAPTURE -> `sram_csb0`=1 immediately, no ack; a following read completes with correct data.
REQ-034 Read with `wbs_cyc_i` dropped in ACCESS -> no ack, FSM in IDLE 2 cycles later; the next write is acked normally.
REQ-035 With `SRAM_WB_READ_CACHE_EN`: two reads of adr 0x3000_0010 -> second acks in 1 cycle with no csb0 pulse. Then a write to that address followed by a read -> 3-cycle latency and the new data.
